// File: rtl/mips_defines.sv
// Shared definitions for the MIPS pipeline front end: fetch FSM encoding,
// the NOP word used for bubbles and the default reset fetch address.
package mips_defines;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_npc.sv
// Redirect target computation for the instruction currently in ID:
// register jump, J-type pseudo-direct jump, or PC-relative branch.
module fetch_npc (
  input  logic [31:0] pc_id,
  input  logic [25:0] instr_id,
  input  logic [31:0] branch_pc,
  input  logic [31:0] jr_pc,
  input  logic        jump_target,
  input  logic        use_reg,
  output logic [31:0] tgt
);

  logic [31:0] pc_id_p4;

  // Targets are relative to the delay slot address; arithmetic wraps mod 2^32.
  assign pc_id_p4 = pc_id + 32'd4;

  always_comb begin
    if (use_reg) begin
      tgt = jr_pc;
    end else if (jump_target) begin
      tgt = {pc_id_p4[31:28], instr_id, 2'b00};
    end else begin
      tgt = pc_id_p4 + branch_pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, the instruction-memory request and the IF/ID register.
// Optional performance counters are built when INSTR_FETCH_PERF_EN is defined.
module instr_fetch
  import mips_defines::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        use_reg,
  input  logic [31:0] jr_pc,
  input  logic [31:0] branch_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        instr_valid_id,
  output logic [31:0] perf_wait_cnt,
  output logic [31:0] perf_bubble_cnt,
  output logic        state_dbg
);

  // Handshakes: imem_req/imem_addr stay asserted and stable in FETCH until the
  // one-cycle imem_valid strobe returns the word; ID takes IF/ID when ~stall.
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_if_q, pc_if_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  pc_id_q, pc_id_d;
  logic [31:0]  instr_id_q, instr_id_d;
  logic         valid_id_q, valid_id_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic         accept;
  logic         redir_now;
  logic [31:0]  tgt;

  assign accept    = ~stall;
  assign redir_now = valid_id_q & accept & (jump_branch | jump_target);

  fetch_npc u_npc (
    .pc_id       (pc_id_q),
    .instr_id    (instr_id_q[25:0]),
    .branch_pc   (branch_pc),
    .jr_pc       (jr_pc),
    .jump_target (jump_target),
    .use_reg     (use_reg),
    .tgt         (tgt)
  );

  always_comb begin
    state_d      = state_q;
    pc_if_d      = pc_if_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    pc_id_d      = pc_id_q;
    instr_id_d   = instr_id_q;
    valid_id_d   = valid_id_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    imem_req     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          pc_if_d      = redir_now ? tgt : redir_pend_q ? redir_pc_q : pc_if_q + 32'd4;
          redir_pend_d = 1'b0;
          if (accept) begin
            pc_id_d    = pc_if_q;
            instr_id_d = imem_rdata;
            valid_id_d = 1'b1;
          end else begin
            buf_pc_d    = pc_if_q;
            buf_instr_d = imem_rdata;
            state_d     = S_HOLD;
          end
        end else begin
          // Bubble keeps the old pc_id; only the word and valid bit change.
          if (accept) begin
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
          end
          // The fetch still in flight is the delay slot; redirect after it lands.
          if (redir_now) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = tgt;
          end
        end
      end
      S_HOLD: begin
        if (accept) begin
          pc_id_d    = buf_pc_q;
          instr_id_d = buf_instr_q;
          valid_id_d = 1'b1;
          state_d    = S_FETCH;
          if (redir_now) begin
            pc_if_d = tgt;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_if_q      <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0;
      pc_id_q      <= 32'h0;
      instr_id_q   <= NOP_INSTR;
      valid_id_q   <= 1'b0;
      buf_pc_q     <= 32'h0;
      buf_instr_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_if_q      <= pc_if_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      pc_id_q      <= pc_id_d;
      instr_id_q   <= instr_id_d;
      valid_id_q   <= valid_id_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
    end
  end

  assign imem_addr      = pc_if_q;
  assign pc_id          = pc_id_q;
  assign instr_id       = instr_id_q;
  assign instr_valid_id = valid_id_q;
  assign state_dbg      = state_q;

`ifdef INSTR_FETCH_PERF_EN
  logic        fetch_wait;
  logic        load_bubble;
  logic [31:0] wait_cnt_q;
  logic [31:0] bubble_cnt_q;

  assign fetch_wait  = (state_q == S_FETCH) & ~imem_valid;
  assign load_bubble = fetch_wait & accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (fetch_wait)  wait_cnt_q   <= wait_cnt_q + 32'd1;
      if (load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_wait_cnt   = wait_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_wait_cnt   = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

  // The delay slot is never itself a redirect.
  redir_in_delay_slot: assert property (@(posedge clk) disable iff (!rst_n)
    !(redir_now && redir_pend_q));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, stall/HOLD, branch, JR with
// slow memory, J resolved out of HOLD, and asynchronous reset mid-fetch.
module tb_instr_fetch;
  import mips_defines::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump_branch;
  logic        jump_target;
  logic        use_reg;
  logic [31:0] jr_pc;
  logic [31:0] branch_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        instr_valid_id;
  logic [31:0] perf_wait_cnt;
  logic [31:0] perf_bubble_cnt;
  logic        state_dbg;

  int errors = 0;
  int checks = 0;
  int lat    = 1;
  int cnt    = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .jump_branch     (jump_branch),
    .jump_target     (jump_target),
    .use_reg         (use_reg),
    .jr_pc           (jr_pc),
    .branch_pc       (branch_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_valid      (imem_valid),
    .pc_id           (pc_id),
    .instr_id        (instr_id),
    .instr_valid_id  (instr_valid_id),
    .perf_wait_cnt   (perf_wait_cnt),
    .perf_bubble_cnt (perf_bubble_cnt),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hF000_0000) return 32'h0800_0040;  // J with index 0x40
    return a;
  endfunction

  // Responds lat cycles after an address is first presented.
  always begin
    @(posedge clk);
    #2;
    imem_valid = 1'b0;
    if (!rst_n || !imem_req) begin
      cnt = 0;
    end else begin
      cnt++;
      if (cnt >= lat) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(imem_addr);
        cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_id(input logic [31:0] pc, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (instr_valid_id && pc_id == pc) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: pc %h never reached ID (last pc_id=%h)", tag, pc, pc_id);
    end
  endtask

  task automatic goto_pc(input logic [31:0] target);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_valid_id && n < 40) begin
      @(negedge clk);
      n++;
    end
    jump_target = 1'b1;
    use_reg     = 1'b1;
    jr_pc       = target;
    @(negedge clk);
    jump_target = 1'b0;
    use_reg     = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] exp;
    repeat (2) @(negedge clk);
    checks++; if (pc_id !== 32'h0) begin errors++; $display("FAIL rst_pc_id: got %h want %h", pc_id, 32'h0); end
    checks++; if (instr_valid_id !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid_id); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_req: got %b/%h want 1/0", imem_req, imem_addr); end
    checks++; if (perf_wait_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0) begin errors++; $display("FAIL rst_perf: got %h/%h want 0/0", perf_wait_cnt, perf_bubble_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (instr_valid_id !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL seq_first: got v=%b addr=%h want 0/0", instr_valid_id, imem_addr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = 32'(i * 4);
      checks++;
      if (instr_valid_id !== 1'b1 || pc_id !== exp || instr_id !== exp || imem_addr !== exp + 32'd4) begin
        errors++;
        $display("FAIL seq_%0d: got v=%b pc=%h instr=%h addr=%h want 1/%h/%h/%h",
                 i, instr_valid_id, pc_id, instr_id, imem_addr, exp, exp, exp + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    wait_id(32'h0000_000C, "stall_reach");
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_addr: got %h want 10", imem_addr); end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || state_dbg !== S_HOLD || pc_id !== 32'hC || instr_id !== 32'hC || instr_valid_id !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: got req=%b st=%b pc=%h instr=%h v=%b want 0/1/c/c/1",
                 i, imem_req, state_dbg, pc_id, instr_id, instr_valid_id);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (pc_id !== 32'h10 || instr_id !== 32'h10 || instr_valid_id !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      errors++;
      $display("FAIL stall_release: got pc=%h instr=%h v=%b req=%b addr=%h want 10/10/1/1/14",
               pc_id, instr_id, instr_valid_id, imem_req, imem_addr);
    end
    @(negedge clk);
    checks++; if (pc_id !== 32'h14 || instr_valid_id !== 1'b1) begin errors++; $display("FAIL stall_resume: got pc=%h v=%b want 14/1", pc_id, instr_valid_id); end
  endtask

  task automatic test_branch();
    goto_pc(32'h0000_0100);
    wait_id(32'h0000_0100, "beq_reach");
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL beq_slot_addr: got %h want 104", imem_addr); end
    jump_branch = 1'b1;
    branch_pc   = 32'h0000_0040;
    @(negedge clk);
    jump_branch = 1'b0;
    checks++;
    if (pc_id !== 32'h104 || instr_id !== 32'h104 || instr_valid_id !== 1'b1 || imem_addr !== 32'h144) begin
      errors++;
      $display("FAIL beq_redirect: got pc=%h instr=%h v=%b addr=%h want 104/104/1/144",
               pc_id, instr_id, instr_valid_id, imem_addr);
    end
    wait_id(32'h0000_0144, "beq_target");
  endtask

  task automatic test_jr_latency();
    goto_pc(32'h0000_0200);
    lat = 3;
    wait_id(32'h0000_0200, "jr_reach");
    jump_target = 1'b1;
    use_reg     = 1'b1;
    jr_pc       = 32'h8000_0010;
    @(negedge clk);
    jump_target = 1'b0;
    use_reg     = 1'b0;
    checks++;
    if (instr_valid_id !== 1'b0 || instr_id !== NOP_INSTR || pc_id !== 32'h200 || imem_addr !== 32'h204) begin
      errors++;
      $display("FAIL jr_pending: got v=%b instr=%h pc=%h addr=%h want 0/0/200/204",
               instr_valid_id, instr_id, pc_id, imem_addr);
    end
    wait_id(32'h0000_0204, "jr_slot");
    checks++; if (imem_addr !== 32'h8000_0010) begin errors++; $display("FAIL jr_target_addr: got %h want 80000010", imem_addr); end
    wait_id(32'h8000_0010, "jr_target");
    checks++; if (instr_id !== 32'h8000_0010) begin errors++; $display("FAIL jr_target_instr: got %h want 80000010", instr_id); end
    lat = 1;
  endtask

  task automatic test_jump_hold();
    goto_pc(32'hF000_0000);
    wait_id(32'hF000_0000, "j_reach");
    checks++; if (instr_id !== 32'h0800_0040 || imem_addr !== 32'hF000_0004) begin errors++; $display("FAIL j_word: got %h/%h want 08000040/f0000004", instr_id, imem_addr); end
    stall       = 1'b1;
    jump_target = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || state_dbg !== S_HOLD || pc_id !== 32'hF000_0000 || instr_valid_id !== 1'b1) begin
        errors++;
        $display("FAIL j_hold: got req=%b st=%b pc=%h v=%b want 0/1/f0000000/1", imem_req, state_dbg, pc_id, instr_valid_id);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    jump_target = 1'b0;
    checks++;
    if (pc_id !== 32'hF000_0004 || instr_id !== 32'hF000_0004 || instr_valid_id !== 1'b1 || imem_addr !== 32'hF000_0100) begin
      errors++;
      $display("FAIL j_release: got pc=%h instr=%h v=%b addr=%h want f0000004/f0000004/1/f0000100",
               pc_id, instr_id, instr_valid_id, imem_addr);
    end
    wait_id(32'hF000_0100, "j_target");
  endtask

  task automatic test_reset_mid_fetch();
    bit found;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (imem_addr == 32'h30) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_reach: addr %h never presented, last %h", 32'h30, imem_addr); end
`ifdef INSTR_FETCH_PERF_EN
    checks++; if (perf_wait_cnt == 32'h0 || perf_bubble_cnt == 32'h0) begin errors++; $display("FAIL mid_perf_run: got %h/%h want nonzero", perf_wait_cnt, perf_bubble_cnt); end
`endif
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_id !== 32'h0 || instr_id !== 32'h0 || instr_valid_id !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b1 || state_dbg !== S_FETCH) begin
      errors++;
      $display("FAIL mid_async: got pc=%h instr=%h v=%b addr=%h req=%b st=%b want 0/0/0/0/1/0",
               pc_id, instr_id, instr_valid_id, imem_addr, imem_req, state_dbg);
    end
    checks++; if (perf_wait_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0) begin errors++; $display("FAIL mid_perf: got %h/%h want 0/0", perf_wait_cnt, perf_bubble_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    lat   = 1;
    wait_id(32'h0000_0000, "mid_restart");
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL mid_next: got %h want 4", imem_addr); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    jump_branch = 1'b0;
    jump_target = 1'b0;
    use_reg     = 1'b0;
    jr_pc       = 32'h0;
    branch_pc   = 32'h0;
    imem_rdata  = 32'h0;
    imem_valid  = 1'b0;
    test_reset();
    test_stall();
    test_branch();
    test_jr_latency();
    test_jump_hold();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline; sits directly upstream of decode.
- Owns the PC and the instruction-memory request handshake, and drives the IF/ID pipeline register that decode reads (pc, instr).
- Consumes decode's redirect outputs (jump_branch, jump_target, use_reg, jr_pc, branch_pc) and its stall, and honours the single MIPS branch delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous reset, active low
- stall  in  1  decode stall; high = ID must hold its instruction
- jump_branch  in  1  conditional branch taken (decode)
- jump_target  in  1  J/JAL/JR/JALR in ID (decode)
- use_reg  in  1  register jump; target = jr_pc
- jr_pc  in  32  register jump target (decode, forwarded)
- branch_pc  in  32  sign-extended word offset, already shifted left by 2
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_rdata  in  32  fetched word; valid only when imem_valid is high
- imem_valid  in  1  one-cycle response strobe; arrives 1 or more cycles after imem_req
- pc_id  out  32  PC of the instruction in ID
- instr_id  out  32  instruction in ID; 32'h0 (NOP) when a bubble is present
- instr_valid_id  out  1  ID holds a real instruction
- perf_wait_cnt  out  32  optional feature counter
- perf_bubble_cnt  out  32  optional feature counter

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc_if = RESET_PC; state = FETCH; redir_pend = 0.
  - pc_id = 0, instr_id = 0, instr_valid_id = 0; perf counters = 0.
- Accept and redirect terms:
  - accept = ~stall.
  - redir_now = instr_valid_id & accept & (jump_branch | jump_target).
  - tgt = use_reg ? jr_pc : jump_target ? {pc_id_p4[31:28], instr_id[25:0], 2'b00} : pc_id_p4 + branch_pc, where pc_id_p4 = pc_id + 4.
  - All PC arithmetic is 32-bit modulo; wrap-around from 32'hFFFF_FFFC to 0 is legal.
- FETCH state:
  - imem_req = 1, imem_addr = pc_if; the address is held stable until imem_valid.
  - On imem_valid: the word's PC is pc_if; pc_if <= npc, where npc = redir_now ? tgt : redir_pend ? redir_pc : pc_if + 4; redir_pend <= 0.
  - On imem_valid with accept: IF/ID <= {pc_if, imem_rdata, valid = 1}; stay in FETCH.
  - On imem_valid with ~accept: buffer <= {pc_if, imem_rdata}; go to HOLD.
  - No imem_valid with accept: IF/ID <= bubble (instr 0, valid 0); pc_id is don't-care but is held.
  - No imem_valid with redir_now: redir_pend <= 1, redir_pc <= tgt. The in-flight fetch is the delay slot.
- HOLD state:
  - imem_req = 0; at most one instruction is buffered and no fetch is in flight.
  - On accept: IF/ID <= buffer (valid 1); go to FETCH. If redir_now is also high, pc_if <= tgt; the buffered word is the delay slot.
  - On ~accept: hold everything.
- Stall with no accept: IF/ID is held unchanged, including the valid bit.
- Invariant: while a branch occupies ID, its delay slot is either in flight (FETCH) or buffered (HOLD). It is never squashed; no flush path exists.
- redir_now while redir_pend is already 1 cannot occur: the delay slot is never a redirect. Assert in simulation only.
- Throughput: 1 instruction per cycle when imem_valid returns every cycle and stall = 0.

Optional Feature:
- Macro INSTR_FETCH_PERF_EN.
- Defined:
  - perf_wait_cnt increments each cycle in FETCH without imem_valid.
  - perf_bubble_cnt increments each cycle a bubble is loaded into IF/ID.
  - Both are 32-bit, wrapping, and cleared by reset.
- Undefined: both ports are tied to 32'h0 and no counter flops exist.

Decomposition:
- Shared package (mips_defines):
  - FETCH/HOLD state encoding (1 bit)
  - NOP_INSTR = 32'h0000_0000
  - default RESET_PC value
- One combinational sub-module, fetch_npc: inputs pc_id, instr_id[25:0], branch_pc, jr_pc, jump_target, use_reg; output tgt.

Test Plan:
- Reset release, imem answers every cycle with rdata = addr, stall = 0 -> imem_addr sequence 0, 4, 8, C; instr_valid_id rises one cycle after the first imem_valid; pc_id tracks that sequence.
- BEQ at 0x100 with branch_pc = 0x40, jump_branch = 1 -> delay slot 0x104 enters ID, next fetch address = 0x144.
- JR at 0x200, jr_pc = 0x8000_0010, with imem latency 3 and the delay-slot fetch still in flight -> redir_pend set; after the 0x204 response, imem_addr = 0x8000_0010.
- stall = 1 for 4 cycles while 0x10 is returned -> HOLD entered, imem_req = 0, IF/ID frozen; on release 0x10 enters ID and fetch resumes at 0x14.
- J at 0xF000_0000 with instr_id[25:0] = 0x0000040, branch in ID stalled while the delay slot is buffered -> on accept, pc_if = 0xF000_0100 and the delay slot 0xF000_0004 enters ID.
- rst_n pulsed low mid-fetch at pc_if = 0x30 -> all outputs return to reset values immediately; the next request is at RESET_PC. With INSTR_FETCH_PERF_EN defined, both counters read 0.
